circuit_sweep_ctrl: RTL and testbench

CIRCUIT_SWEEP_CTRL -- requirements
Module: circuit_sweep_ctrl

---
 rtl/circuit_sweep_ctrl.sv | 153 +++++++++++++++
 tb/tb_circuit_sweep_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/circuit_sweep_ctrl.sv
// Exhaustive-range sweep controller for a 7-input combinational circuit:
// drives each vector for a settle cycle, samples y, and accumulates a count and MISR signature.
module circuit_sweep_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic [6:0] first_vec,
   input  logic [6:0] last_vec,
   input  logic       y_in,
   output logic [6:0] vec_out,
   output logic       busy,
   output logic       done,
   output logic [7:0] ones_cnt,
   output logic [7:0] sig
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_APPLY  = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Feedback taps of the signature register: bits 7, 5, 4 and 3
   localparam logic [7:0] MISR_TAPS = 8'hB8;

   state_t     state_reg;
   state_t     state_next;
   logic [6:0] vec_reg;
   logic [6:0] vec_next;
   logic [6:0] last_reg;
   logic [6:0] last_next;
   logic [7:0] ones_reg;
   logic [7:0] ones_next;
   logic [7:0] sig_reg;
   logic [7:0] sig_next;
   logic [7:0] misr_value;
   logic       accept;
   logic       take_sample;
   logic       at_last;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         vec_reg   <= 7'd0;
         last_reg  <= 7'd0;
         ones_reg  <= 8'd0;
         sig_reg   <= 8'd0;
      end else begin
         state_reg <= state_next;
         vec_reg   <= vec_next;
         last_reg  <= last_next;
         ones_reg  <= ones_next;
         sig_reg   <= sig_next;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   assign at_last = (vec_reg == last_reg);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start && !abort) begin
               state_next = ST_APPLY;
            end
         end
         ST_APPLY: begin
            state_next = abort ? ST_IDLE : ST_SAMPLE;
         end
         ST_SAMPLE: begin
            if (abort) begin
               state_next = ST_IDLE;
            end else if (at_last) begin
               state_next = ST_DONE;
            end else begin
               state_next = ST_APPLY;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath: vector register, bounds latch, counters
   // ------------------------------------------------------------------
   assign accept      = (state_reg == ST_IDLE) && start && !abort;
   assign take_sample = (state_reg == ST_SAMPLE) && !abort;

   assign misr_value[0] = (^(sig_reg & MISR_TAPS)) ^ y_in;
   generate
      for (genvar gi = 1; gi < 8; gi++) begin : g_misr_shift
         assign misr_value[gi] = sig_reg[gi-1];
      end
   endgenerate

   always_comb begin
      vec_next  = vec_reg;
      last_next = last_reg;
      ones_next = ones_reg;
      sig_next  = sig_reg;
      if (accept) begin
         vec_next  = first_vec;
         last_next = last_vec;
         ones_next = 8'd0;
         sig_next  = 8'd0;
      end else if (take_sample) begin
         ones_next = ones_reg + {7'd0, y_in};
         sig_next  = misr_value;
         // The 7-bit add wraps 127 -> 0 naturally for wrap-around sweeps
         if (!at_last) begin
            vec_next = vec_reg + 7'd1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Output logic
   // ------------------------------------------------------------------
   always_comb begin
      busy    = 1'b0;
      done    = 1'b0;
      vec_out = 7'd0;
      case (state_reg)
         ST_APPLY, ST_SAMPLE: begin
            busy    = 1'b1;
            vec_out = vec_reg;
         end
         ST_DONE: begin
            done = 1'b1;
         end
         default: begin
            busy    = 1'b0;
         end
      endcase
   end

   assign ones_cnt = ones_reg;
   assign sig      = sig_reg;

endmodule

// File: tb/tb_circuit_sweep_ctrl.sv
// Randomized and directed bench for circuit_sweep_ctrl; the circuit under control
// is modelled as a 128-entry truth table indexed by vec_out.
module tb_circuit_sweep_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         abort;
   logic [6:0]   first_vec;
   logic [6:0]   last_vec;
   logic         y_in;
   logic [6:0]   vec_out;
   logic         busy;
   logic         done;
   logic [7:0]   ones_cnt;
   logic [7:0]   sig;
   logic [127:0] truth;

   int compared   = 0;
   int mismatched = 0;

   circuit_sweep_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .first_vec (first_vec),
      .last_vec  (last_vec),
      .y_in      (y_in),
      .vec_out   (vec_out),
      .busy      (busy),
      .done      (done),
      .ones_cnt  (ones_cnt),
      .sig       (sig)
   );

   always #5 clk = ~clk;

   assign y_in = truth[vec_out];

   // Runs one sweep. abort_at > 0 raises abort at that cycle index (index k is the
   // negedge after the k-th edge following the accepting edge). Returns observed values.
   task automatic run_sweep(input logic [6:0] f, input logic [6:0] l, input int abort_at,
                            input string name, output logic [7:0] got_ones,
                            output logic [7:0] got_sig, output int got_done_idx);
      logic [6:0] diff;
      logic [6:0] v;
      logic [6:0] ev;
      logic [7:0] e_ones;
      logic [7:0] e_sig;
      int         n;
      int         n_samples;
      diff = l - f;
      n = int'(diff) + 1;
      n_samples = (abort_at > 0) ? (abort_at - 1) / 2 : n;
      e_ones = 8'd0;
      e_sig  = 8'd0;
      for (int i = 0; i < n_samples; i++) begin
         v = f + 7'(i);
         e_ones = e_ones + 8'(truth[v]);
         e_sig  = {e_sig[6:0], (^(e_sig & 8'hB8)) ^ truth[v]};
      end
      got_done_idx = 0;

      @(negedge clk);
      first_vec = f;
      last_vec  = l;
      start     = 1'b1;
      abort     = 1'b0;
      @(posedge clk);
      #1;
      start     = 1'b0;
      first_vec = 7'($urandom);
      last_vec  = 7'($urandom);

      for (int idx = 1; idx <= 2 * n + 1; idx++) begin
         @(negedge clk);
         if (abort_at > 0 && idx == abort_at + 1) begin
            abort = 1'b0;
            compared++;
            if (busy !== 1'b0 || done !== 1'b0 || vec_out !== 7'd0) begin
               mismatched++;
               $display("FAIL %s abort_idle: busy=%b done=%b vec_out=%0d required 0/0/0",
                        name, busy, done, vec_out);
            end
            for (int k = 0; k < 4; k++) begin
               compared++;
               if (ones_cnt !== e_ones || sig !== e_sig || done !== 1'b0 || busy !== 1'b0) begin
                  mismatched++;
                  $display("FAIL %s abort_hold: ones=%0d sig=%h done=%b busy=%b required ones=%0d sig=%h done=0 busy=0",
                           name, ones_cnt, sig, done, busy, e_ones, e_sig);
               end
               @(negedge clk);
            end
            got_ones = ones_cnt;
            got_sig  = sig;
            $display("sweep %s first=%0d last=%0d aborted at %0d ones=%0d sig=%h",
                     name, f, l, abort_at, ones_cnt, sig);
            return;
         end
         if (idx <= 2 * n) begin
            ev = f + 7'((idx - 1) / 2);
            compared++;
            if (vec_out !== ev || busy !== 1'b1 || done !== 1'b0) begin
               mismatched++;
               $display("FAIL %s sweep_cycle%0d: vec_out=%0d busy=%b done=%b required vec_out=%0d busy=1 done=0",
                        name, idx, vec_out, busy, done, ev);
            end
            start = 1'($urandom_range(0, 1));
         end else begin
            compared++;
            if (done !== 1'b1 || busy !== 1'b0 || vec_out !== 7'd0) begin
               mismatched++;
               $display("FAIL %s done_cycle: done=%b busy=%b vec_out=%0d required done=1 busy=0 vec_out=0",
                        name, done, busy, vec_out);
            end
            start = 1'b0;
            abort = 1'($urandom_range(0, 1));
         end
         if (done === 1'b1 && got_done_idx == 0) got_done_idx = idx;
         if (idx == abort_at) begin
            abort = 1'b1;
            start = 1'b0;
         end
      end

      @(negedge clk);
      abort = 1'b0;
      compared++;
      if (got_done_idx != 2 * n + 1) begin
         mismatched++;
         $display("FAIL %s done_latency: got %0d required %0d", name, got_done_idx, 2 * n + 1);
      end
      compared++;
      if (busy !== 1'b0 || done !== 1'b0 || vec_out !== 7'd0) begin
         mismatched++;
         $display("FAIL %s post_idle: busy=%b done=%b vec_out=%0d required 0/0/0",
                  name, busy, done, vec_out);
      end
      compared++;
      if (ones_cnt !== e_ones || sig !== e_sig) begin
         mismatched++;
         $display("FAIL %s result: ones=%0d sig=%h required ones=%0d sig=%h",
                  name, ones_cnt, sig, e_ones, e_sig);
      end
      got_ones = ones_cnt;
      got_sig  = sig;
      $display("sweep %s first=%0d last=%0d N=%0d done_idx=%0d ones=%0d sig=%h",
               name, f, l, n, got_done_idx, ones_cnt, sig);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b1;
      abort = 1'b0;
      first_vec = 7'd9;
      last_vec  = 7'd20;
      truth = '1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      compared++;
      if (busy !== 1'b0 || done !== 1'b0 || vec_out !== 7'd0 || ones_cnt !== 8'd0 || sig !== 8'd0) begin
         mismatched++;
         $display("FAIL reset_state: busy=%b done=%b vec=%0d ones=%0d sig=%h required all zero",
                  busy, done, vec_out, ones_cnt, sig);
      end
      start = 1'b0;
      rst   = 1'b0;
      $display("reset applied");
   endtask

   task automatic test_directed();
      logic [7:0] o;
      logic [7:0] s;
      int         d;
      truth = '1;
      run_sweep(7'd0, 7'd3, 0, "ones_0_3", o, s, d);
      compared++;
      if (o !== 8'd4 || s !== 8'h0F || d != 9) begin
         mismatched++;
         $display("FAIL ones_0_3_const: ones=%0d sig=%h done_idx=%0d required 4/0F/9", o, s, d);
      end
      truth = '0;
      run_sweep(7'd126, 7'd1, 0, "wrap_126_1", o, s, d);
      compared++;
      if (o !== 8'd0 || s !== 8'h00 || d != 9) begin
         mismatched++;
         $display("FAIL wrap_126_1_const: ones=%0d sig=%h done_idx=%0d required 0/00/9", o, s, d);
      end
      truth = '1;
      run_sweep(7'd5, 7'd5, 0, "single_5", o, s, d);
      compared++;
      if (o !== 8'd1 || s !== 8'h01 || d != 3) begin
         mismatched++;
         $display("FAIL single_5_const: ones=%0d sig=%h done_idx=%0d required 1/01/3", o, s, d);
      end
   endtask

   task automatic test_full_range();
      logic [7:0] o;
      logic [7:0] s;
      int         d;
      truth = '1;
      run_sweep(7'd0, 7'd127, 0, "full_0_127", o, s, d);
      compared++;
      if (o !== 8'h80 || d != 257) begin
         mismatched++;
         $display("FAIL full_const: ones=%0d done_idx=%0d required 128/257", o, d);
      end
   endtask

   task automatic test_abort();
      logic [7:0] o;
      logic [7:0] s;
      int         d;
      truth = '1;
      run_sweep(7'd0, 7'd3, 6, "abort_0_3", o, s, d);
      compared++;
      if (o !== 8'd2 || s !== 8'h03) begin
         mismatched++;
         $display("FAIL abort_const: ones=%0d sig=%h required 2/03", o, s);
      end
      for (int r = 0; r < 3; r++) begin
         logic [6:0] f;
         logic [6:0] l;
         int         n;
         f = 7'($urandom);
         l = f + 7'($urandom_range(0, 12));
         n = int'(7'(l - f)) + 1;
         truth = {$urandom, $urandom, $urandom, $urandom};
         run_sweep(f, l, $urandom_range(1, 2 * n - 1), "abort_rand", o, s, d);
      end
   endtask

   task automatic test_reset_mid_and_start_abort();
      truth = '1;
      @(negedge clk);
      first_vec = 7'd10;
      last_vec  = 7'd40;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      start = 1'b1;
      abort = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      compared++;
      if (busy !== 1'b0 || done !== 1'b0 || vec_out !== 7'd0 || ones_cnt !== 8'd0 || sig !== 8'd0) begin
         mismatched++;
         $display("FAIL mid_reset: busy=%b done=%b vec=%0d ones=%0d sig=%h required all zero",
                  busy, done, vec_out, ones_cnt, sig);
      end
      start = 1'b1;
      abort = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         compared++;
         if (busy !== 1'b0 || done !== 1'b0 || vec_out !== 7'd0 || ones_cnt !== 8'd0 || sig !== 8'd0) begin
            mismatched++;
            $display("FAIL start_abort_idle: busy=%b done=%b vec=%0d ones=%0d sig=%h required all zero",
                     busy, done, vec_out, ones_cnt, sig);
         end
      end
      start = 1'b0;
      abort = 1'b0;
      $display("mid-sweep reset and start+abort in idle exercised");
   endtask

   task automatic test_random();
      logic [7:0] o;
      logic [7:0] s;
      int         d;
      for (int r = 0; r < 6; r++) begin
         logic [6:0] f;
         logic [6:0] l;
         f = 7'($urandom);
         l = f + 7'($urandom_range(0, 24));
         truth = {$urandom, $urandom, $urandom, $urandom};
         run_sweep(f, l, 0, "random", o, s, d);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] o;
      logic [7:0] s;
      int         d;
      truth = {$urandom, $urandom, $urandom, $urandom};
      run_sweep(7'd120, 7'd6, 0, "b2b_a", o, s, d);
      run_sweep(7'd60, 7'd62, 0, "b2b_b", o, s, d);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      first_vec = 7'd0;
      last_vec = 7'd0;
      truth = '0;
      test_reset();
      test_directed();
      test_full_range();
      test_abort();
      test_reset_mid_and_start_abort();
      test_random();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
